// File: rtl/energy_tracker_pkg.sv
// rtl/energy_tracker_pkg.sv - shared types and default widths for the energy best tracker
package energy_tracker_pkg;

  localparam int DATASPIN         = 256;
  localparam int ENERGY_TOTAL_BIT = 32;
  localparam int STALL_CNT_BIT    = 16;
  localparam int INDEX_BIT        = 32;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    DONE
  } tracker_state_e;

endpackage

// File: rtl/energy_best_tracker.sv
// rtl/energy_best_tracker.sv - keeps the minimum-energy sample and its spin vector, flags convergence
module energy_best_tracker
  import energy_tracker_pkg::*;
#(
  parameter int DATASPIN         = energy_tracker_pkg::DATASPIN,
  parameter int ENERGY_TOTAL_BIT = energy_tracker_pkg::ENERGY_TOTAL_BIT,
  parameter int STALL_CNT_BIT    = energy_tracker_pkg::STALL_CNT_BIT,
  parameter int INDEX_BIT        = energy_tracker_pkg::INDEX_BIT
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        en_i,
  input  logic                        clear_i,
  input  logic [STALL_CNT_BIT-1:0]    stall_limit_i,
  input  logic                        energy_valid_i,
  output logic                        energy_ready_o,
  input  logic [ENERGY_TOTAL_BIT-1:0] energy_i,
  input  logic [DATASPIN-1:0]         spin_i,
  output logic                        best_valid_o,
  output logic [ENERGY_TOTAL_BIT-1:0] best_energy_o,
  output logic [DATASPIN-1:0]         best_spin_o,
  output logic [INDEX_BIT-1:0]        best_index_o,
  output logic [INDEX_BIT-1:0]        sample_count_o,
  output logic                        count_overflow_o,
  output logic                        result_valid_o,
  input  logic                        result_ready_i
);

  tracker_state_e r_state, w_state_nxt;

  logic                        r_best_valid;
  logic [ENERGY_TOTAL_BIT-1:0] r_best_energy;
  logic [DATASPIN-1:0]         r_best_spin;
  logic [INDEX_BIT-1:0]        r_best_index;
  logic [INDEX_BIT-1:0]        r_sample_count;
  logic                        r_count_overflow;
  logic [STALL_CNT_BIT-1:0]    r_stall_count;

  logic                        w_accept;
  logic                        w_improve;
  logic                        w_converge;
  logic                        w_restart;
  logic [STALL_CNT_BIT-1:0]    w_stall_nxt;

  assign energy_ready_o = (r_state == TRACK) && en_i && !clear_i;
  assign w_accept       = energy_ready_o && energy_valid_i;
  assign w_improve      = !r_best_valid || ($signed(energy_i) < $signed(r_best_energy));
  // Results stay visible in IDLE and are wiped only on the way back into TRACK.
  assign w_restart      = clear_i || ((r_state == IDLE) && en_i);

  always_comb begin
    w_stall_nxt = r_stall_count;
    if (w_improve) begin
      w_stall_nxt = '0;
    end else if (!(&r_stall_count)) begin
      w_stall_nxt = r_stall_count + 1'b1;
    end
  end

  assign w_converge = w_accept && (stall_limit_i != '0) && (w_stall_nxt == stall_limit_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear_i) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (en_i)           w_state_nxt = TRACK;
        TRACK:   if (w_converge)     w_state_nxt = DONE;
        DONE:    if (result_ready_i) w_state_nxt = IDLE;
        default:                     w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_best_valid     <= 1'b0;
      r_best_energy    <= '0;
      r_best_spin      <= '0;
      r_best_index     <= '0;
      r_sample_count   <= '0;
      r_count_overflow <= 1'b0;
      r_stall_count    <= '0;
    end else if (w_restart) begin
      r_best_valid     <= 1'b0;
      r_best_energy    <= '0;
      r_best_spin      <= '0;
      r_best_index     <= '0;
      r_sample_count   <= '0;
      r_count_overflow <= 1'b0;
      r_stall_count    <= '0;
    end else if (w_accept) begin
      if (&r_sample_count) begin
        r_count_overflow <= 1'b1;
      end else begin
        r_sample_count <= r_sample_count + 1'b1;
      end
      r_stall_count <= w_stall_nxt;
      if (w_improve) begin
        r_best_valid  <= 1'b1;
        r_best_energy <= energy_i;
        r_best_spin   <= spin_i;
        r_best_index  <= r_sample_count;
      end
    end
  end

  assign best_valid_o     = r_best_valid;
  assign best_energy_o    = r_best_energy;
  assign best_spin_o      = r_best_spin;
  assign best_index_o     = r_best_index;
  assign sample_count_o   = r_sample_count;
  assign count_overflow_o = r_count_overflow;
  assign result_valid_o   = (r_state == DONE);

endmodule

// File: tb/tb_energy_best_tracker.sv
// tb/tb_energy_best_tracker.sv - randomized and directed bench for energy_best_tracker
module tb_energy_best_tracker;

  localparam int DS = 256;
  localparam int EW = 32;
  localparam int SW = 16;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          clr;
  logic [SW-1:0] stall_limit;
  logic          energy_valid;
  logic          energy_ready;
  logic [EW-1:0] energy;
  logic [DS-1:0] spin;
  logic          best_valid;
  logic [EW-1:0] best_energy;
  logic [DS-1:0] best_spin;
  logic [IW-1:0] best_index;
  logic [IW-1:0] sample_count;
  logic          count_overflow;
  logic          result_valid;
  logic          result_ready;

  int total = 0;
  int bad   = 0;

  // Reference: a run is "tracking" or "done"; neither means idle.
  bit            m_track, m_done, m_bvalid, m_ovf;
  logic [EW-1:0] m_be;
  logic [DS-1:0] m_bs;
  int unsigned   m_bi, m_cnt;

  always #5 clk = ~clk;

  energy_best_tracker dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .en_i             (en),
    .clear_i          (clr),
    .stall_limit_i    (stall_limit),
    .energy_valid_i   (energy_valid),
    .energy_ready_o   (energy_ready),
    .energy_i         (energy),
    .spin_i           (spin),
    .best_valid_o     (best_valid),
    .best_energy_o    (best_energy),
    .best_spin_o      (best_spin),
    .best_index_o     (best_index),
    .sample_count_o   (sample_count),
    .count_overflow_o (count_overflow),
    .result_valid_o   (result_valid),
    .result_ready_i   (result_ready)
  );

  task automatic chk(input string tag, input logic [DS-1:0] got, input logic [DS-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DS-1:0] rand_spin();
    logic [DS-1:0] s;
    for (int i = 0; i < DS / 32; i++) s[i*32 +: 32] = $urandom;
    return s;
  endfunction

  task automatic model_wipe();
    m_bvalid = 0; m_ovf = 0; m_be = '0; m_bs = '0; m_bi = 0; m_cnt = 0;
  endtask

  task automatic check_outputs();
    chk("best_valid",     best_valid,     m_bvalid);
    chk("best_energy",    best_energy,    m_be);
    chk("best_spin",      best_spin,      m_bs);
    chk("best_index",     best_index,     m_bi);
    chk("sample_count",   sample_count,   m_cnt);
    chk("count_overflow", count_overflow, m_ovf);
    chk("result_valid",   result_valid,   m_done);
  endtask

  task automatic cycle();
    bit            rdy, acc;
    logic [EW-1:0] e;
    logic [DS-1:0] s;
    logic [SW-1:0] lim;
    int unsigned   stall;
    bit            c, ena, rr;
    #1;
    rdy = m_track && en && !clr;
    chk("energy_ready", energy_ready, rdy);
    acc = rdy && energy_valid;
    e = energy; s = spin; lim = stall_limit; c = clr; ena = en; rr = result_ready;
    @(posedge clk);
    if (c) begin
      model_wipe(); m_track = 0; m_done = 0;
    end else if (!m_track && !m_done) begin
      if (ena) begin model_wipe(); m_track = 1; end
    end else if (m_track) begin
      if (acc) begin
        if (!m_bvalid || $signed(e) < $signed(m_be)) begin
          m_bvalid = 1; m_be = e; m_bs = s; m_bi = m_cnt;
        end
        m_cnt++;
        stall = m_cnt - 1 - m_bi;
        if (stall > 65535) stall = 65535;
        if (lim != 0 && stall == lim) begin m_track = 0; m_done = 1; end
      end
    end else if (rr) begin
      m_done = 0;
    end
    #1;
    check_outputs();
  endtask

  task automatic offer(input int e, input logic [DS-1:0] s);
    energy = e; spin = s; energy_valid = 1; cycle();
  endtask

  initial begin
    logic [DS-1:0] sp;
    int            en_cycles, c0;
    rst_n = 0; en = 0; clr = 0; stall_limit = '0; energy_valid = 0;
    energy = '0; spin = '0; result_ready = 0;
    m_track = 0; m_done = 0; model_wipe();
    #3;
    chk("reset_ready", energy_ready, 1'b0);
    check_outputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // decreasing energies then a plateau
    en = 1; stall_limit = 3;
    cycle();
    offer(10, rand_spin()); offer(5, rand_spin()); offer(-2, rand_spin());
    offer(-2, rand_spin()); offer(7, rand_spin()); offer(0, rand_spin());
    chk("plateau_best_e", best_energy, 32'hFFFF_FFFE);
    chk("plateau_idx", best_index, 2);
    chk("plateau_cnt", sample_count, 6);
    chk("plateau_done", result_valid, 1'b1);

    // DONE holds off upstream and waits for the host
    result_ready = 0;
    for (int i = 0; i < 5; i++) offer(-50, rand_spin());
    chk("done_hold_e", best_energy, 32'hFFFF_FFFE);
    result_ready = 1; cycle();
    result_ready = 0; energy_valid = 0;
    chk("after_hs_rv", result_valid, 1'b0);
    cycle();
    chk("reenter_bv", best_valid, 1'b0);

    // most-positive versus most-negative
    stall_limit = 0;
    offer(32'h7FFF_FFFF, rand_spin());
    sp = rand_spin();
    offer(32'h8000_0000, sp);
    chk("neg_best_e", best_energy, 32'h8000_0000);
    chk("neg_best_spin", best_spin, sp);

    // enable toggling every two cycles under held valid
    c0 = sample_count; en_cycles = 0;
    for (int i = 0; i < 16; i++) begin
      en = ((i / 2) % 2) == 0;
      if (en) en_cycles++;
      offer(100 + i, rand_spin());
    end
    en = 1;
    chk("bp_count", sample_count - c0, en_cycles);

    // clear with a sample offered in the same cycle
    clr = 1; offer(-1000, rand_spin());
    clr = 0;
    chk("clr_bv", best_valid, 1'b0);
    chk("clr_cnt", sample_count, 0);
    cycle();

    // no convergence with limit 0, then tighten the limit mid-run
    offer(-100, rand_spin());
    for (int i = 0; i < 1000; i++) offer(int'($urandom_range(0, 1100)) - 100, rand_spin());
    chk("lim0_no_done", result_valid, 1'b0);
    stall_limit = 1001;
    offer(5, rand_spin());
    chk("late_limit_done", result_valid, 1'b1);
    result_ready = 1; cycle();
    result_ready = 0; cycle();
    stall_limit = 0;
    for (int i = 0; i < 4; i++) offer(i, rand_spin());

    // asynchronous reset with upstream still valid
    #2 rst_n = 0;
    #1;
    chk("arst_ready", energy_ready, 1'b0);
    m_track = 0; m_done = 0; model_wipe();
    check_outputs();
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 3; i++) offer(77, rand_spin());

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      en           = ($urandom_range(0, 9) < 8);
      energy_valid = ($urandom_range(0, 9) < 7);
      energy       = int'($urandom_range(0, 40)) - 20;
      spin         = rand_spin();
      result_ready = ($urandom_range(0, 9) < 3);
      clr          = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 49) == 0) stall_limit = $urandom_range(0, 6);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
